rng_histogram: RTL and testbench

- Downstream consumer of the random generator's 4-bit output.
- Accepts 4-bit samples through a valid/ready handshake and buffers them in a small FIFO.
- Keeps a 16-bin occurrence histogram in the shared 16-bit word memory. Each bin is a saturating 16-bit counter updated by read-modify-write.
- Gives the team a hardware distribution check on generator quality.

---
 rtl/rng_histogram.sv | 143 ++++++++++++++
 tb/tb_rng_histogram.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_histogram.sv
// Histogram of 4-bit random samples kept as 16 saturating bins in word memory.
// Ports: clock/reset, sample_* valid/ready input, clear, mem_* bus, busy,
// total_count, overflow.
module rng_histogram #(
    parameter logic [15:0] ADDR_BASE  = 16'h0040,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        clear,
    output logic [15:0] mem_address,
    output logic        mem_wr_en,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    output logic        busy,
    output logic [15:0] total_count,
    output logic        overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR
    } state_t;

    state_t        state;
    logic [3:0]    idx;
    logic [3:0]    bin_r;
    logic [15:0]   rd_r;
    logic          clear_pending;
    logic [3:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic push;
    logic pop;
    logic flush;

    assign sample_ready = (count < CW'(FIFO_DEPTH)) &&
                          (state != S_CLEAR) && !clear_pending;
    assign busy  = (state != S_IDLE) || (count != '0);
    assign push  = sample_valid && sample_ready;
    assign flush = (state == S_IDLE) && clear_pending;
    assign pop   = (state == S_IDLE) && !clear_pending && (count != '0);

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_CLEAR;
            idx           <= 4'd0;
            bin_r         <= 4'd0;
            rd_r          <= 16'd0;
            clear_pending <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            mem_address   <= ADDR_BASE;
            mem_wr_en     <= 1'b0;
            mem_data_in   <= 16'd0;
            total_count   <= 16'd0;
            overflow      <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end

            // A clear during the sweep restarts it directly instead of
            // queueing a second sweep.
            if (clear && state != S_CLEAR) clear_pending <= 1'b1;

            unique case (state)
                S_CLEAR: begin
                    mem_wr_en   <= 1'b1;
                    mem_data_in <= 16'd0;
                    if (clear) begin
                        mem_address <= ADDR_BASE;
                        idx         <= 4'd1;
                    end else begin
                        mem_address <= ADDR_BASE + {12'd0, idx};
                        idx         <= idx + 4'd1;
                        if (idx == 4'hF) state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    mem_wr_en <= 1'b0;
                    if (clear_pending) begin
                        clear_pending <= 1'b0;
                        total_count   <= 16'd0;
                        overflow      <= 1'b0;
                        idx           <= 4'd0;
                        state         <= S_CLEAR;
                    end else if (count != '0) begin
                        bin_r       <= fifo_q[rd_ptr];
                        mem_address <= ADDR_BASE + {12'd0, fifo_q[rd_ptr]};
                        state       <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid now; present the saturated
                    // increment for the whole WR cycle.
                    rd_r        <= mem_data_out;
                    mem_address <= ADDR_BASE + {12'd0, bin_r};
                    mem_wr_en   <= 1'b1;
                    mem_data_in <= (mem_data_out == 16'hFFFF) ?
                                   16'hFFFF : mem_data_out + 16'd1;
                    state       <= S_WR;
                end
                S_WR: begin
                    mem_wr_en <= 1'b0;
                    if (rd_r == 16'hFFFF) overflow <= 1'b1;
                    if (total_count != 16'hFFFF)
                        total_count <= total_count + 16'd1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_histogram.sv
// Bench for rng_histogram: word memory model, scoreboard of expected writes.
// Ports: none (top level).
module tb_rng_histogram;

    logic        clock;
    logic        reset;
    logic [3:0]  sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        clear;
    logic [15:0] mem_address;
    logic        mem_wr_en;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        busy;
    logic [15:0] total_count;
    logic        overflow;

    rng_histogram dut (
        .clock        (clock),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .clear        (clear),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .total_count  (total_count),
        .overflow     (overflow)
    );

    logic [15:0] mem [0:65535];
    logic        bd_en;
    logic [15:0] bd_addr;
    logic [15:0] bd_data;

    always @(posedge clock) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (mem_wr_en) mem[mem_address] <= mem_data_in;
        mem_data_out <= mem[mem_address];
    end

    initial clock = 1'b1;
    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q [$];
    logic [15:0] model [16];
    logic [15:0] exp_total;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [31:0] e;
        if (!reset && mem_wr_en) begin
            e = (q.size() != 0) ? q.pop_front() : 32'hDEADDEAD;
            chk("mem_wr", {mem_address, mem_data_in}, e);
        end
    end

    task automatic model_zero();
        for (int k = 0; k < 16; k++) model[k] = 16'd0;
        exp_total = 16'd0;
    endtask

    task automatic push_sweep();
        for (int k = 0; k < 16; k++)
            q.push_back({16'h0040 + 16'(k), 16'h0000});
    endtask

    task automatic expect_sample(input logic [3:0] b);
        logic [15:0] nv;
        nv = (model[b] == 16'hFFFF) ? 16'hFFFF : model[b] + 16'd1;
        model[b] = nv;
        q.push_back({16'h0040 + {12'd0, b}, nv});
        if (exp_total != 16'hFFFF) exp_total = exp_total + 16'd1;
    endtask

    // Called at a negedge; returns one negedge after the handshake.
    task automatic send(input logic [3:0] b);
        sample_in    = b;
        sample_valid = 1'b1;
        for (int i = 0; i < 50 && !sample_ready; i++) @(negedge clock);
        if (!sample_ready) chk("ready_timeout", {31'd0, sample_ready}, 1);
        else expect_sample(b);
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (!busy && !mem_wr_en && q.size() == 0) break;
        end
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_q"}, q.size(), 0);
    endtask

    task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        bd_addr = a;
        bd_data = d;
        bd_en   = 1'b1;
        @(negedge clock);
        bd_en   = 1'b0;
    endtask

    initial begin
        int acc;
        logic saw_low;
        reset        = 1'b1;
        sample_in    = 4'd0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        bd_en        = 1'b0;
        bd_addr      = 16'd0;
        bd_data      = 16'd0;
        model_zero();
        push_sweep();

        #20;
        chk("rst_addr", {16'd0, mem_address}, 32'h0040);
        chk("rst_wr", {31'd0, mem_wr_en}, 0);
        chk("rst_din", {16'd0, mem_data_in}, 0);
        chk("rst_ready", {31'd0, sample_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_total", {16'd0, total_count}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        #5 reset = 1'b0;

        wait_idle("sweep");
        chk("sweep_ready", {31'd0, sample_ready}, 1);

        send(4'h5);
        @(negedge clock);
        chk("rd_addr", {16'd0, mem_address}, 32'h0045);
        chk("rd_wr", {31'd0, mem_wr_en}, 0);
        wait_idle("single");
        chk("single_total", {16'd0, total_count}, {16'd0, exp_total});
        chk("single_ovf", {31'd0, overflow}, 0);
        chk("single_mem", {16'd0, mem[16'h0045]}, 1);

        acc     = 0;
        saw_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample_in    = 4'h3;
            sample_valid = 1'b1;
            if (sample_ready) begin
                expect_sample(4'h3);
                acc++;
            end else begin
                saw_low = 1'b1;
            end
            @(negedge clock);
        end
        sample_valid = 1'b0;
        wait_idle("hold");
        chk("hold_ready_drop", {31'd0, saw_low}, 1);
        chk("hold_mem", {16'd0, mem[16'h0043]}, acc);
        chk("hold_total", {16'd0, total_count}, {16'd0, exp_total});

        bd_write(16'h004A, 16'hFFFF);
        model[10] = 16'hFFFF;
        send(4'hA);
        wait_idle("sat");
        chk("sat_ovf", {31'd0, overflow}, 1);
        chk("sat_total", {16'd0, total_count}, {16'd0, exp_total});
        chk("sat_mem", {16'd0, mem[16'h004A]}, 32'hFFFF);

        send(4'h1);
        send(4'h2);
        send(4'h3);
        // First sample is in WAIT now; its write stays, the rest drop.
        clear = 1'b1;
        void'(q.pop_back());
        void'(q.pop_back());
        push_sweep();
        @(negedge clock);
        clear = 1'b0;
        model_zero();
        wait_idle("clear");
        chk("clear_total", {16'd0, total_count}, 0);
        chk("clear_ovf", {31'd0, overflow}, 0);
        chk("clear_mem41", {16'd0, mem[16'h0041]}, 0);
        chk("clear_ready", {31'd0, sample_ready}, 1);

        send(4'h1);
        wait_idle("post_clear");
        chk("post_clear_total", {16'd0, total_count}, 1);

        bd_write(16'h0047, 16'h1234);
        model[7] = 16'h1234;
        send(4'h7);
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("wr_before_rst", {31'd0, mem_wr_en}, 1);
        reset = 1'b1;
        #1;
        chk("arst_wr", {31'd0, mem_wr_en}, 0);
        chk("arst_addr", {16'd0, mem_address}, 32'h0040);
        chk("arst_busy", {31'd0, busy}, 1);
        chk("arst_ready", {31'd0, sample_ready}, 0);
        chk("arst_total", {16'd0, total_count}, 0);
        chk("arst_q", q.size(), 1);
        q.delete();
        model_zero();
        @(negedge clock);
        chk("abort_mem47", {16'd0, mem[16'h0047]}, 32'h1234);
        push_sweep();
        @(negedge clock);
        reset = 1'b0;
        wait_idle("resweep");
        chk("resweep_mem47", {16'd0, mem[16'h0047]}, 0);
        chk("resweep_ready", {31'd0, sample_ready}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
